msx_keyboard_matrix: RTL

- Keyboard stage feeding the PPI. Converts host PS/2 key events into an MSX key matrix of 11 rows x 8 columns, active-low.
- The PPI port C low nibble selects the row. This block returns that row's column byte to PPI port B input.
- Also drives the CAPS LED from PPI port C bit 6.
- Sits between the HPS keyboard interface and the PPI instance.

---
 rtl/msx_kbd_pkg.sv | 20 ++
 rtl/msx_keymap.sv | 115 +++++++++++
 rtl/msx_keyboard_matrix.sv | 113 +++++++++++
 3 files changed

// File: rtl/msx_kbd_pkg.sv
// rtl/msx_kbd_pkg.sv - shared types and constants for the MSX keyboard matrix
package msx_kbd_pkg;

  localparam int MSX_ROWS = 11;

  typedef enum logic [1:0] {IDLE, LOOKUP, APPLY} kbd_state_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] row;
    logic [2:0] col;
  } keymap_entry_t;

  localparam keymap_entry_t KEY_NONE = '{valid: 1'b0, row: 4'd0, col: 3'd0};

  function automatic keymap_entry_t key_at(input logic [3:0] row, input logic [2:0] col);
    key_at = '{valid: 1'b1, row: row, col: col};
  endfunction

endpackage

// File: rtl/msx_keymap.sv
// rtl/msx_keymap.sv - PS/2 set 2 {ext, code} to MSX matrix position, registered ROM
module msx_keymap
  import msx_kbd_pkg::*;
(
  input  logic          clk,
  input  logic [8:0]    i_addr,
  output keymap_entry_t o_entry
);

  keymap_entry_t w_entry;
  keymap_entry_t r_entry;

  // International layout; anything not listed (fake shifts, E1 pause, ...) is unmapped.
  always_comb begin
    w_entry = KEY_NONE;
    case (i_addr)
      9'h045: w_entry = key_at(4'd0, 3'd0);  // 0
      9'h016: w_entry = key_at(4'd0, 3'd1);
      9'h01E: w_entry = key_at(4'd0, 3'd2);
      9'h026: w_entry = key_at(4'd0, 3'd3);
      9'h025: w_entry = key_at(4'd0, 3'd4);
      9'h02E: w_entry = key_at(4'd0, 3'd5);
      9'h036: w_entry = key_at(4'd0, 3'd6);
      9'h03D: w_entry = key_at(4'd0, 3'd7);
      9'h03E: w_entry = key_at(4'd1, 3'd0);  // 8
      9'h046: w_entry = key_at(4'd1, 3'd1);
      9'h04E: w_entry = key_at(4'd1, 3'd2);
      9'h055: w_entry = key_at(4'd1, 3'd3);
      9'h05D: w_entry = key_at(4'd1, 3'd4);
      9'h054: w_entry = key_at(4'd1, 3'd5);
      9'h05B: w_entry = key_at(4'd1, 3'd6);
      9'h04C: w_entry = key_at(4'd1, 3'd7);
      9'h052: w_entry = key_at(4'd2, 3'd0);  // '
      9'h00E: w_entry = key_at(4'd2, 3'd1);
      9'h041: w_entry = key_at(4'd2, 3'd2);
      9'h049: w_entry = key_at(4'd2, 3'd3);
      9'h04A: w_entry = key_at(4'd2, 3'd4);
      9'h01C: w_entry = key_at(4'd2, 3'd6);  // A
      9'h032: w_entry = key_at(4'd2, 3'd7);
      9'h021: w_entry = key_at(4'd3, 3'd0);  // C
      9'h023: w_entry = key_at(4'd3, 3'd1);
      9'h024: w_entry = key_at(4'd3, 3'd2);
      9'h02B: w_entry = key_at(4'd3, 3'd3);
      9'h034: w_entry = key_at(4'd3, 3'd4);
      9'h033: w_entry = key_at(4'd3, 3'd5);
      9'h043: w_entry = key_at(4'd3, 3'd6);
      9'h03B: w_entry = key_at(4'd3, 3'd7);
      9'h042: w_entry = key_at(4'd4, 3'd0);  // K
      9'h04B: w_entry = key_at(4'd4, 3'd1);
      9'h03A: w_entry = key_at(4'd4, 3'd2);
      9'h031: w_entry = key_at(4'd4, 3'd3);
      9'h044: w_entry = key_at(4'd4, 3'd4);
      9'h04D: w_entry = key_at(4'd4, 3'd5);
      9'h015: w_entry = key_at(4'd4, 3'd6);
      9'h02D: w_entry = key_at(4'd4, 3'd7);
      9'h01B: w_entry = key_at(4'd5, 3'd0);  // S
      9'h02C: w_entry = key_at(4'd5, 3'd1);
      9'h03C: w_entry = key_at(4'd5, 3'd2);
      9'h02A: w_entry = key_at(4'd5, 3'd3);
      9'h01D: w_entry = key_at(4'd5, 3'd4);
      9'h022: w_entry = key_at(4'd5, 3'd5);
      9'h035: w_entry = key_at(4'd5, 3'd6);
      9'h01A: w_entry = key_at(4'd5, 3'd7);
      9'h012: w_entry = key_at(4'd6, 3'd0);  // left shift
      9'h059: w_entry = key_at(4'd6, 3'd0);
      9'h014: w_entry = key_at(4'd6, 3'd1);
      9'h011: w_entry = key_at(4'd6, 3'd2);
      9'h058: w_entry = key_at(4'd6, 3'd3);
      9'h111: w_entry = key_at(4'd6, 3'd4);  // right alt = CODE
      9'h005: w_entry = key_at(4'd6, 3'd5);
      9'h006: w_entry = key_at(4'd6, 3'd6);
      9'h004: w_entry = key_at(4'd6, 3'd7);
      9'h00C: w_entry = key_at(4'd7, 3'd0);  // F4
      9'h003: w_entry = key_at(4'd7, 3'd1);
      9'h076: w_entry = key_at(4'd7, 3'd2);
      9'h00D: w_entry = key_at(4'd7, 3'd3);
      9'h00A: w_entry = key_at(4'd7, 3'd4);
      9'h066: w_entry = key_at(4'd7, 3'd5);
      9'h00B: w_entry = key_at(4'd7, 3'd6);
      9'h05A: w_entry = key_at(4'd7, 3'd7);
      9'h15A: w_entry = key_at(4'd7, 3'd7);
      9'h029: w_entry = key_at(4'd8, 3'd0);  // space
      9'h16C: w_entry = key_at(4'd8, 3'd1);
      9'h170: w_entry = key_at(4'd8, 3'd2);
      9'h171: w_entry = key_at(4'd8, 3'd3);
      9'h16B: w_entry = key_at(4'd8, 3'd4);
      9'h175: w_entry = key_at(4'd8, 3'd5);
      9'h172: w_entry = key_at(4'd8, 3'd6);
      9'h174: w_entry = key_at(4'd8, 3'd7);
      9'h07C: w_entry = key_at(4'd9, 3'd0);  // keypad *
      9'h079: w_entry = key_at(4'd9, 3'd1);
      9'h14A: w_entry = key_at(4'd9, 3'd2);
      9'h070: w_entry = key_at(4'd9, 3'd3);
      9'h069: w_entry = key_at(4'd9, 3'd4);
      9'h072: w_entry = key_at(4'd9, 3'd5);
      9'h07A: w_entry = key_at(4'd9, 3'd6);
      9'h06B: w_entry = key_at(4'd9, 3'd7);
      9'h073: w_entry = key_at(4'd10, 3'd0); // keypad 5
      9'h074: w_entry = key_at(4'd10, 3'd1);
      9'h06C: w_entry = key_at(4'd10, 3'd2);
      9'h075: w_entry = key_at(4'd10, 3'd3);
      9'h07D: w_entry = key_at(4'd10, 3'd4);
      9'h07B: w_entry = key_at(4'd10, 3'd5);
      9'h071: w_entry = key_at(4'd10, 3'd7);
      default: w_entry = KEY_NONE;
    endcase
  end

  always_ff @(posedge clk) begin
    r_entry <= w_entry;
  end

  assign o_entry = r_entry;

endmodule

// File: rtl/msx_keyboard_matrix.sv
// rtl/msx_keyboard_matrix.sv - PS/2 event to MSX 11x8 active-low key matrix for the PPI
module msx_keyboard_matrix
  import msx_kbd_pkg::*;
#(
  parameter int ROWS       = MSX_ROWS,
  parameter int PEND_DEPTH = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] ps2_key,
  input  logic        release_all,
  input  logic [3:0]  row_sel,
  input  logic        caps_n,
  output logic [7:0]  col_dout,
  output logic        caps_led,
  output logic        evt_overflow,
  output logic        busy
);

  localparam logic [4:0] ROWS_L = 5'(ROWS);

  if (PEND_DEPTH != 1) begin : g_pend_depth_unsupported
    $error("msx_keyboard_matrix: only PEND_DEPTH = 1 is implemented");
  end

  logic                  r_last_toggle;
  logic                  r_pend_valid;
  logic                  r_pend_pressed;
  logic [8:0]            r_pend_key;
  kbd_state_t            r_state;
  logic [8:0]            r_lk_addr;
  logic                  r_lk_pressed;
  logic [ROWS-1:0][7:0]  r_matrix;
  keymap_entry_t         w_entry;
  logic                  w_new_evt;
  logic                  w_take;

  assign w_new_evt = (ps2_key[10] != r_last_toggle);
  assign w_take    = (r_state == IDLE) && r_pend_valid;

  msx_keymap u_keymap (
    .clk     (clk),
    .i_addr  (r_lk_addr),
    .o_entry (w_entry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_toggle  <= ps2_key[10];
      r_pend_valid   <= 1'b0;
      r_pend_pressed <= 1'b0;
      r_pend_key     <= 9'd0;
      r_state        <= IDLE;
      r_lk_addr      <= 9'd0;
      r_lk_pressed   <= 1'b0;
      r_matrix       <= '1;
      evt_overflow   <= 1'b0;
      busy           <= 1'b0;
    end else begin
      r_last_toggle <= ps2_key[10];
      if (w_new_evt && r_pend_valid)
        evt_overflow <= 1'b1;
      // release_all flushes everything, including a lookup about to be applied
      if (release_all) begin
        r_pend_valid <= 1'b0;
        r_matrix     <= '1;
        r_state      <= IDLE;
        busy         <= 1'b0;
      end else begin
        if (w_new_evt && !r_pend_valid) begin
          r_pend_valid   <= 1'b1;
          r_pend_pressed <= ps2_key[9];
          r_pend_key     <= ps2_key[8:0];
        end else if (w_take) begin
          r_pend_valid <= 1'b0;
        end
        case (r_state)
          IDLE: begin
            if (r_pend_valid) begin
              r_lk_addr    <= r_pend_key;
              r_lk_pressed <= r_pend_pressed;
              r_state      <= LOOKUP;
              busy         <= 1'b1;
            end
          end
          LOOKUP: r_state <= APPLY;
          APPLY: begin
            if (w_entry.valid && ({1'b0, w_entry.row} < ROWS_L))
              r_matrix[w_entry.row][w_entry.col] <= ~r_lk_pressed;
            r_state <= IDLE;
            busy    <= 1'b0;
          end
          default: begin
            r_state <= IDLE;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

  // Read sees the matrix before any same-edge APPLY write.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_dout <= 8'hFF;
      caps_led <= 1'b0;
    end else begin
      caps_led <= ~caps_n;
      col_dout <= ({1'b0, row_sel} < ROWS_L) ? r_matrix[row_sel] : 8'hFF;
    end
  end

endmodule
